// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: receiver bit timing, RX FIFO depth and the
// pointer-width helper used by the FIFO.
package uart_rx_fifo_pkg;

  localparam int CLKS_PER_BIT = 868;
  localparam int FIFO_DEPTH   = 16;

  // One extra MSB beyond the address distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// RX FIFO storage: DEPTH x 8, synchronous write, asynchronous read.
module uart_fifo_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind the UART receiver, with
// registered level/full/valid and a sticky overflow flag.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_d_i,
  input  logic                     rx_done_i,
  output logic [7:0]               rd_d_o,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [ptr_w(DEPTH)-1:0]  level_o,
  output logic                     full_o,
  output logic                     overflow_o,
  input  logic                     overflow_clr_i
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          pop, wr_acc;
  logic [7:0]    mem_rdata;

  assign pop    = valid_q & rd_ready_i;
  // A pop frees the head slot this cycle, so a write may land even when full.
  assign wr_acc = rx_done_i & (~full_q | pop);

  always_comb begin
    wptr_d  = wptr_q + PW'(wr_acc);
    rptr_d  = rptr_q + PW'(pop);
    level_d = wptr_d - rptr_d;
    full_d  = (level_d == PW'(DEPTH));
    valid_d = (level_d != '0);
    ovf_d   = (rx_done_i & full_q & ~pop) | (ovf_q & ~overflow_clr_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  uart_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (rx_d_i),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // Storage is never reset; gating on valid keeps stale bytes off the bus.
  assign rd_d_o     = valid_q ? mem_rdata : 8'h00;
  assign rd_valid_o = valid_q;
  assign level_o    = level_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_d_i;
  logic          rx_done_i;
  logic [7:0]    rd_d_o;
  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [PW-1:0] level_o;
  logic          full_o;
  logic          overflow_o;
  logic          overflow_clr_i;

  int checks   = 0;
  int failures = 0;

  byte unsigned exp_q[$];
  bit           ovf_m = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_d_i         (rx_d_i),
    .rx_done_i      (rx_done_i),
    .rd_d_o         (rd_d_o),
    .rd_valid_o     (rd_valid_o),
    .rd_ready_i     (rd_ready_i),
    .level_o        (level_o),
    .full_o         (full_o),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor + model: outputs compared mid-cycle, then the model advances on
  // the inputs that the next rising edge will see.
  always @(negedge clk) begin
    bit pop, wr;
    if (reset) begin
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      chk("rd_valid", int'(rd_valid_o), int'(exp_q.size() != 0));
      chk("level", int'(level_o), exp_q.size());
      chk("full", int'(full_o), int'(exp_q.size() == DEPTH));
      chk("overflow", int'(overflow_o), int'(ovf_m));
      if (exp_q.size() != 0) chk("rd_data", int'(rd_d_o), int'(exp_q[0]));
      pop = (exp_q.size() != 0) && rd_ready_i;
      wr  = rx_done_i && (exp_q.size() < DEPTH || pop);
      ovf_m = (rx_done_i && exp_q.size() == DEPTH && !pop) || (ovf_m && !overflow_clr_i);
      if (pop) void'(exp_q.pop_front());
      if (wr) exp_q.push_back(rx_d_i);
    end
  end

  task automatic step(input logic d, input logic [7:0] b, input logic r, input logic c);
    rx_done_i = d; rx_d_i = b; rd_ready_i = r; overflow_clr_i = c;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && rd_valid_o; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", int'(rd_valid_o), 0);
  endtask

  initial begin
    reset = 1'b1; rx_done_i = 1'b0; rx_d_i = 8'h00; rd_ready_i = 1'b0; overflow_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_level", int'(level_o), 0);
    chk("reset_valid", int'(rd_valid_o), 0);
    chk("reset_rd_d", int'(rd_d_o), 0);
    reset = 1'b0;

    // Single byte held without ready
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_data", int'(rd_d_o), 8'hA5);
    chk("a5_level", int'(level_o), 1);
    repeat (10) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_hold", int'(rd_d_o), 8'hA5);
    drain();

    // Fill to full, then pop everything in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    chk("fill_full", int'(full_o), 1);
    // Dropped write while full, then clear
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk("drop_ovf", int'(overflow_o), 1);
    chk("drop_level", int'(level_o), DEPTH);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_clr", int'(overflow_o), 0);
    drain();

    // Full with simultaneous write and pop
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    chk("wrpop_level", int'(level_o), DEPTH);
    chk("wrpop_ovf", int'(overflow_o), 0);
    drain();

    // Clear and new overflow in the same cycle: set wins
    for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    step(1'b1, 8'hEF, 1'b0, 1'b1);
    chk("ovf_set_wins", int'(overflow_o), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    drain();

    // 40-byte stream popping every other cycle: pointers wrap several times
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'(i & 1), 1'b0);
    drain();

    // Random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 5));
    drain();

    // Mid-operation reset at level 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    chk("pre_rst_level", int'(level_o), 5);
    reset = 1'b1;
    #1;
    chk("rst_imm_level", int'(level_o), 0);
    chk("rst_imm_valid", int'(rd_valid_o), 0);
    chk("rst_imm_full", int'(full_o), 0);
    chk("rst_imm_rd_d", int'(rd_d_o), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("post_rst_first", int'(rd_d_o), 8'h3C);
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
